// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch
// Brief   : Instruction fetch stage. It owns the fetch PC, reads the
//           combinational instruction ROM and queues {pc, inst} pairs in a
//           small in-order buffer that feeds decode over valid/ready.
// Rev     : 1.0  initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] fetch_cnt
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_fetch_cnt;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_buf_pc   [DEPTH];
    logic [31:0]        r_buf_inst [DEPTH];

    logic w_pop;
    logic w_push;
    logic w_unused_bits;

    // out_valid comes straight from the count so it drops the moment reset asserts.
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;
    assign w_push    = ~redirect_valid & ~halt & ((r_count < c_DEPTH) | w_pop);

    assign imem_pc       = r_fetch_pc;
    assign fetch_cnt     = r_fetch_cnt;
    assign out_pc        = out_valid ? r_buf_pc[r_rd_ptr]   : 32'h0;
    assign out_inst      = out_valid ? r_buf_inst[r_rd_ptr] : 32'h0;
    assign w_unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_fetch_cnt <= 32'h0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else if (redirect_valid) begin
            // A concurrent pop is simply absorbed by the flush.
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + c_PTR_W'(1);
                r_fetch_pc  <= r_fetch_pc + 32'd4;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
            r_buf_inst[r_wr_ptr] <= imem_inst;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifu_fetch
// Brief   : Self-checking bench for ifu_fetch against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
    localparam int          c_DEPTH    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] fetch_cnt;

    int          n_tests;
    int          n_fail;
    ent_t        m_q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_cnt;

    ifu_fetch #(
        .RESET_PC (c_RESET_PC),
        .DEPTH    (c_DEPTH)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] pc);
        logic [31:0] idx;
        idx = (pc - c_RESET_PC) >> 2;
        case (idx)
            32'd0:   return 32'h0000_0013;
            32'd1:   return 32'h0010_0093;
            32'd2:   return 32'h0020_0113;
            default: return (pc * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        endcase
    endfunction

    assign imem_inst = rom(imem_pc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_valid = (m_q.size() > 0);
        e_pc    = e_valid ? m_q[0].pc   : 32'h0;
        e_inst  = e_valid ? m_q[0].inst : 32'h0;
        chk("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
        chk("out_pc",    out_pc,    e_pc);
        chk("out_inst",  out_inst,  e_inst);
        chk("imem_pc",   imem_pc,   m_fpc);
        chk("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc = c_RESET_PC;
        m_cnt = 32'h0;
    endtask

    // One clock: drive at the falling edge, check, advance the model, take the edge.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc, input logic h);
        bit pop;
        bit push;
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        #1;
        check_outputs();
        pop  = (m_q.size() > 0) && rdy;
        push = !rv && !h && ((m_q.size() < c_DEPTH) || pop);
        if (rv) begin
            m_q.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back('{pc: m_fpc, inst: rom(m_fpc)});
                m_fpc = m_fpc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
        @(posedge clk);
    endtask

    // Called right after a rising edge: assert reset between edges, hold one edge, release.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_imem_pc",   imem_pc,   c_RESET_PC);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_out_pc",    out_pc,    32'h0);
        chk("reset_imem_pc",   imem_pc,   c_RESET_PC);
        chk("reset_fetch_cnt", fetch_cnt, 32'h0);
        #1;
        rst_n = 1'b1;

        // Streaming with decode always ready.
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        // Back-pressure, then drain.
        mid_reset();
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        // Redirect with a full buffer and no pop, to an unaligned target.
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h8000_0103, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        // Halt with entries buffered, then resume.
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        // Redirect together with a pop, and together with halt.
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h8000_0200, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h8000_0300, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        // PC wrap across 2^32.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        // Reset between edges while streaming.
        mid_reset();
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                  $urandom, $urandom_range(0, 7) == 0);
            if (i == 200) mid_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
